ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset)
//  to the keyboard over the open-drain PS/2 clock/data lines.
//  Complements the existing PS/2 receiver on the same two wires.
//  Receiver must ignore bus traffic while busy=1.
// PARAMETERS
//  INHIBIT_CYC  5000     clk cycles ps2 clock held low before request (100 us @ 50 MHz)
//  TIMEOUT_CYC  1000000  max clk cycles from request to ACK-edge before abort (20 ms @ 50 MHz)
// PORTS
//  clk          in   1  system clock (50 MHz)
//  rst          in   1  synchronous reset, active-high
//  tx_valid     in   1  request to send tx_data; accepted when tx_valid & tx_ready
//  tx_data      in   8  command byte, sent LSB first
//  tx_ready     out  1  1 in IDLE only
//  busy         out  1  1 from accept until return to IDLE
//  done         out  1  one-cycle pulse: transfer finished, device ACKed (data low at ACK edge)
//  err          out  1  one-cycle pulse: timeout or NACK; mutually exclusive with done
//  ps2_clk_in   in   1  raw PS/2 clock pin (async)
//  ps2_data_in  in   1  raw PS/2 data pin (async)
//  ps2_clk_oe   out  1  1 = drive PS/2 clock low, 0 = release (open drain)
//  ps2_data_oe  out  1  1 = drive PS/2 data low, 0 = release
// BEHAVIOUR
//  Reset: state IDLE; tx_ready=1; busy=0; done=err=0; both oe=0; counters 0.
//  Inputs pass a 3-flop synchronizer; fall = sync[2] & ~sync[1] (one-cycle pulse per falling edge).
//  States and transitions:
//   IDLE    tx_valid -> latch byte; compute odd parity p = ~^tx_data; go INHIBIT.
//   INHIBIT clk_oe=1, data_oe=0, for exactly INHIBIT_CYC cycles; then REQ.
//   REQ     data_oe=1 (start bit 0), clk_oe=0; edge counter k=0; go SHIFT.
//   SHIFT   on each fall: k++; k=1..8 -> data_oe=~byte[k-1]; k=9 -> data_oe=~p;
//           k=10 -> data_oe=0 (stop bit, line released);
//           k=11 -> sample synced data: 0 -> ACK ok, 1 -> NACK; go WAITHI.
//   WAITHI  wait until synced clk=1 AND synced data=1; then pulse done (ACK) or err (NACK); IDLE.
//  data_oe changes only the cycle after a fall (device samples on rising edge).
//  Timeout: counter starts at REQ entry and runs through SHIFT and WAITHI.
//   On reaching TIMEOUT_CYC: both oe=0, err pulse, IDLE. Timeout takes priority over a same-cycle fall.
//  tx_valid while busy: ignored, not queued; tx_ready=0.
//  Stray falls in IDLE/INHIBIT: ignored.
//  rst mid-transfer: next edge releases both lines; no done/err pulse.
//  Latency: done fires >= INHIBIT_CYC+11 device clock periods after accept.
// CONFIGURATION
//  PS2_TX_RETRY_EN defined: on NACK or timeout, re-enter INHIBIT with the same byte.
//   Up to 2 retries; err only after the 3rd failure; done/err still pulse exactly once.
//  Undefined: first NACK or timeout pulses err and returns to IDLE.
// STRUCTURE
//  ps2_pkg: state enum (IDLE, INHIBIT, REQ, SHIFT, WAITHI); command constants
//   (CMD_SET_LED=8'hED, CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, RSP_ACK=8'hFA);
//   function odd_parity(byte).
//  Sub-module ps2_line_sync: 3-flop sync + falling-edge pulse; one instance per line.
//   Shareable with the receiver.
// TESTING
//  1 Send 8'hED; device model clocks at 12.5 kHz, ACKs.
//    -> bits seen at rising edges: 0,1,0,1,1,0,1,1,1, parity 1, stop 1; done=1 for one cycle.
//  2 Send 8'h00 -> parity bit 1. Send 8'h01 -> parity bit 0. Both done.
//  3 Device never clocks -> clk_oe low for exactly INHIBIT_CYC cycles;
//    err at TIMEOUT_CYC after REQ; both oe=0.
//  4 Device leaves data high at edge 11 (NACK) -> err, no done.
//    With PS2_TX_RETRY_EN: 3 attempts, then err.
//  5 tx_valid=1 with 8'hF4 while busy -> ignored; only the first byte appears on the bus.
//  6 rst asserted after edge 5 -> next cycle oe=0, tx_ready=1;
//    a new 8'hFF then transfers cleanly with done.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter (and receiver).
//   - FSM state encodings (legacy-compatible localparam constants)
//   - common keyboard command / response bytes
//   - line indices for the clock/data synchronizer array
//   - odd_parity(): PS/2 frame parity bit for a data byte
package ps2_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_INHIBIT = 3'd1;
    localparam state_t ST_REQ     = 3'd2;
    localparam state_t ST_SHIFT   = 3'd3;
    localparam state_t ST_WAITHI  = 3'd4;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] RSP_ACK     = 8'hFA;

    localparam int NUM_LINES = 2;
    localparam int LINE_CLK  = 0;
    localparam int LINE_DATA = 1;

    // Odd parity: the returned bit makes the total count of ones (data + parity) odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 3-flop synchronizer for one raw PS/2 pin plus a falling-edge pulse.
// Shareable with the PS/2 receiver.
//   clk    in  system clock
//   rst    in  synchronous reset, active-high
//   pin    in  raw asynchronous PS/2 pin
//   level  out synchronized line level
//   fall   out one-cycle pulse per falling edge of the synchronized line
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    logic [2:0] sync;

    // Reset to the idle (released, pulled-up) level so leaving reset never
    // produces a spurious falling edge.
    always_ff @(posedge clk) begin
        if (rst) sync <= 3'b111;
        else     sync <= {sync[1:0], pin};
    end

    assign level = sync[1];
    assign fall  = sync[2] & ~sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter. Sends one command byte to the
// keyboard over the open-drain clock/data lines (inhibit, request-to-send,
// 11 device-clocked bits, ACK check).
//   clk, rst      system clock, synchronous active-high reset
//   tx_valid/tx_data/tx_ready   byte request handshake (accepted in IDLE only)
//   busy          high from accept until back in IDLE; receiver ignores the bus then
//   done / err    one-cycle pulses: ACKed transfer / NACK or timeout
//   ps2_clk_in, ps2_data_in     raw pins
//   ps2_clk_oe, ps2_data_oe     1 = pull line low, 0 = release
// Build option: define PS2_TX_RETRY_EN to retry a NACKed or timed-out byte up
// to two more times before reporting err.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYC = 5000,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    // One counter serves both the inhibit interval and the transfer timeout;
    // the two never overlap.
    localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [NUM_LINES-1:0] pins, lvl, fall;

    assign pins[LINE_CLK]  = ps2_clk_in;
    assign pins[LINE_DATA] = ps2_data_in;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_sync
        ps2_line_sync u_sync (
            .clk   (clk),
            .rst   (rst),
            .pin   (pins[i]),
            .level (lvl[i]),
            .fall  (fall[i])
        );
    end

    // Data-line edges matter only to the receiver.
    logic unused_data_fall;
    assign unused_data_fall = fall[LINE_DATA];

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       k;        // device clock falls seen in SHIFT
    logic [7:0]       shreg;
    logic             par;
    logic             ack;
`ifdef PS2_TX_RETRY_EN
    logic [1:0]       tries;
`endif

    logic in_flight, timeout, finish, clk_fall, data_s;

    assign clk_fall  = fall[LINE_CLK];
    assign data_s    = lvl[LINE_DATA];
    assign in_flight = (state == ST_REQ) || (state == ST_SHIFT) || (state == ST_WAITHI);
    assign timeout   = in_flight && (cnt == TMO_LAST);
    assign finish    = (state == ST_WAITHI) && lvl[LINE_CLK] && data_s;

    assign tx_ready = (state == ST_IDLE);
    assign busy     = ~tx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            k           <= '0;
            shreg       <= '0;
            par         <= 1'b0;
            ack         <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            tries       <= '0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            // Timeout is checked first so it wins over a fall in the same cycle.
            if (timeout || (finish && !ack)) begin
`ifdef PS2_TX_RETRY_EN
                if (tries != 2'd2) begin
                    tries       <= tries + 2'd1;
                    cnt         <= '0;
                    ps2_clk_oe  <= 1'b1;
                    ps2_data_oe <= 1'b0;
                    state       <= ST_INHIBIT;
                end else begin
                    err         <= 1'b1;
                    cnt         <= '0;
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= ST_IDLE;
                end
`else
                err         <= 1'b1;
                cnt         <= '0;
                ps2_clk_oe  <= 1'b0;
                ps2_data_oe <= 1'b0;
                state       <= ST_IDLE;
`endif
            end else if (finish) begin
                done  <= 1'b1;
                cnt   <= '0;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (tx_valid) begin
                            shreg       <= tx_data;
                            par         <= odd_parity(tx_data);
                            cnt         <= '0;
                            ps2_clk_oe  <= 1'b1;
                            ps2_data_oe <= 1'b0;
                            state       <= ST_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                            tries       <= '0;
`endif
                        end
                    end
                    ST_INHIBIT: begin
                        if (cnt == INH_LAST) begin
                            // Release clock and pull data low (start bit) together.
                            cnt         <= '0;
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b1;
                            state       <= ST_REQ;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    ST_REQ: begin
                        cnt   <= cnt + 1'b1;
                        k     <= '0;
                        state <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        cnt <= cnt + 1'b1;
                        // Drive the next bit just after each fall so it is stable
                        // by the device's rising-edge sample.
                        if (clk_fall) begin
                            k <= k + 4'd1;
                            if (k < 4'd8) begin
                                ps2_data_oe <= ~shreg[k[2:0]];
                            end else if (k == 4'd8) begin
                                ps2_data_oe <= ~par;
                            end else if (k == 4'd9) begin
                                ps2_data_oe <= 1'b0;
                            end else begin
                                ack   <= ~data_s;
                                state <= ST_WAITHI;
                            end
                        end
                    end
                    ST_WAITHI: begin
                        cnt <= cnt + 1'b1;
                    end
                    default: begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        state       <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed/randomized bench for ps2_host_tx with a behavioural
// PS/2 keyboard model on the open-drain lines and a frame-level reference.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 50;
    localparam int TMO  = 2000;
    localparam int HALF = 20;
`ifdef PS2_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_ready, busy, done, err, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low = 1'b0, dev_data_low = 1'b0;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

    int compared = 0, mismatched = 0;

    ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .busy(busy), .done(done), .err(err),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #10 clk = ~clk;

    // Bus monitor, sampled on the falling clock edge.
    int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int   run_len = 0, last_inh = 0, t_req = 0, t_err = 0;
    logic prev_clk_oe = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (err) begin
            err_cnt <= err_cnt + 1;
            t_err   <= cyc;
        end
        if (done && err) both_cnt <= both_cnt + 1;
        if (ps2_clk_oe) run_len <= run_len + 1;
        else if (run_len != 0) begin
            last_inh <= run_len;
            run_len  <= 0;
        end
        if (prev_clk_oe && !ps2_clk_oe) t_req <= cyc;
        prev_clk_oe <= ps2_clk_oe;
    end

    initial begin
        #1_900_000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected summary");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference frame as seen by the device: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic p;
        p = (($countones(b) % 2) == 0);
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic send(input logic [7:0] b);
        for (int i = 0; i < 20000 && !tx_ready; i++) step(1);
        tx_valid = 1'b1;
        tx_data  = b;
        step(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            step(1);
            if (tx_ready) ok = 1'b1;
        end
        step(2);
        check(tag, ok, 1'b1);
    endtask

    // Keyboard model: waits for request-to-send, then clocks nfall bits,
    // sampling data at each rising edge and ACKing (data low) before edge 11.
    task automatic dev_xfer(input int nfall, input bit ack, output logic [10:0] frame,
                            output bit seen);
        seen  = 1'b0;
        frame = '0;
        for (int i = 0; i < INH + 200 && !seen; i++) begin
            step(1);
            if (ps2_data_in == 1'b0 && ps2_clk_in == 1'b1) seen = 1'b1;
        end
        if (!seen) return;
        step(HALF);
        frame[0] = ps2_data_in;
        for (int k = 1; k <= nfall; k++) begin
            dev_clk_low = 1'b1;
            step(HALF);
            dev_clk_low = 1'b0;
            if (k <= 10) frame[k] = ps2_data_in;
            if (k == 10) begin
                step(HALF / 2);
                dev_data_low = ack;
                step(HALF - HALF / 2);
            end else begin
                step(HALF);
            end
        end
        step(4);
        dev_data_low = 1'b0;
    endtask

    task automatic xfer_ok(input string tag, input logic [7:0] b);
        int d0, e0;
        logic [10:0] fr;
        bit seen;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        dev_xfer(11, 1'b1, fr, seen);
        check({tag, "_rts"}, seen, 1'b1);
        check({tag, "_frame"}, fr, exp_frame(b));
        wait_idle({tag, "_idle"}, 2000);
        check({tag, "_done"}, done_cnt - d0, 1);
        check({tag, "_err"}, err_cnt - e0, 0);
        check({tag, "_inhibit"}, last_inh, INH);
    endtask

    initial begin
        int d0, e0;
        logic [7:0] b;
        logic [10:0] fr;
        bit seen;

        // Reset state
        step(3);
        check("rst_ready", tx_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_clk_oe", ps2_clk_oe, 1'b0);
        check("rst_data_oe", ps2_data_oe, 1'b0);
        rst = 1'b0;
        step(5);

        // Known commands and parity corners
        xfer_ok("set_led", CMD_SET_LED);
        xfer_ok("zero", 8'h00);
        xfer_ok("one", 8'h01);

        // Random bytes
        for (int i = 0; i < 4; i++) xfer_ok("rand", 8'($urandom_range(0, 255)));

        // Device never clocks: timeout measured from clock release
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'($urandom_range(0, 255)));
        step(3);
        check("tmo_busy", busy, 1'b1);
        wait_idle("tmo_idle", 3 * (INH + TMO) + 200);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_done", done_cnt - d0, 0);
        check("tmo_len", t_err - t_req, TMO);
        check("tmo_inhibit", last_inh, INH);
        check("tmo_clk_oe", ps2_clk_oe, 1'b0);
        check("tmo_data_oe", ps2_data_oe, 1'b0);

        // NACK (retried when the retry build option is on)
        d0 = done_cnt;
        e0 = err_cnt;
        b  = 8'($urandom_range(0, 255));
        send(b);
        for (int a = 0; a < ATTEMPTS; a++) begin
            dev_xfer(11, 1'b0, fr, seen);
            check("nack_rts", seen, 1'b1);
            check("nack_frame", fr, exp_frame(b));
        end
        wait_idle("nack_idle", 2000);
        check("nack_err", err_cnt - e0, 1);
        check("nack_done", done_cnt - d0, 0);

        // tx_valid while busy is dropped
        d0 = done_cnt;
        b  = 8'($urandom_range(0, 255));
        if (b == CMD_ENABLE) b = CMD_SET_LED;
        send(b);
        step(2);
        tx_valid = 1'b1;
        tx_data  = CMD_ENABLE;
        step(20);
        check("busy_ready", tx_ready, 1'b0);
        tx_valid = 1'b0;
        dev_xfer(11, 1'b1, fr, seen);
        check("busy_frame", fr, exp_frame(b));
        wait_idle("busy_idle", 2000);
        check("busy_done", done_cnt - d0, 1);
        step(10);
        check("busy_no_requeue", busy, 1'b0);

        // Reset after device edge 5: bit 4 is 0 so data is being pulled low
        d0 = done_cnt;
        e0 = err_cnt;
        b  = 8'($urandom_range(0, 255)) & 8'hEF;
        send(b);
        dev_xfer(5, 1'b1, fr, seen);
        check("mid_data_low", ps2_data_oe, 1'b1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("mid_clk_oe", ps2_clk_oe, 1'b0);
        check("mid_data_oe", ps2_data_oe, 1'b0);
        check("mid_ready", tx_ready, 1'b1);
        step(10);
        check("mid_done", done_cnt - d0, 0);
        check("mid_err", err_cnt - e0, 0);
        xfer_ok("after_rst", CMD_RESET);

        check("done_err_exclusive", both_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
